// File: rtl/adder_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adder_arbiter                                                    |
// | Brief   : Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ    |
// |           requesters through a one-entry result register.                  |
// |           Define ADDER_ARB_CARRY_EN to add the rsp_carry output.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic                       rsp_carry
`endif
);

  localparam int             IDW        = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] c_LAST_IDX = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_found;
  logic             w_can_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDW-1:0]   r_id;

  // First valid requester at or above r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_can_accept = !reset && ((r_state == S_EMPTY) || rsp_ready);
  assign w_xfer       = w_can_accept && w_found;
  assign req_ready    = w_xfer ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  assign w_op_a = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_op_b = req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];

`ifdef ADDER_ARB_CARRY_EN
  logic [WIDTH:0] w_add;
  logic           r_carry;
  assign w_add = {1'b0, w_op_a} + {1'b0, w_op_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_carry <= 1'b0;
    end else if (w_xfer) begin
      r_carry <= w_add[WIDTH];
    end
  end

  assign rsp_carry = r_carry;
`else
  logic [WIDTH-1:0] w_add;
  assign w_add = w_op_a + w_op_b;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready && !w_xfer) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum    <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_sum    <= w_add[WIDTH-1:0];
      r_id     <= w_gnt_idx;
      r_rr_ptr <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_adder_arbiter                                                 |
// | Brief   : Scoreboard bench for adder_arbiter (directed + random traffic).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  typedef struct {
    logic [WIDTH-1:0] sum;
    int               id;
    logic             carry;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic [1:0]               rsp_id;
`ifdef ADDER_ARB_CARRY_EN
  logic                     rsp_carry;
`endif

  int               checks   = 0;
  int               failures = 0;
  int               m_ptr    = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] a_op[NUM_REQ];
  logic [WIDTH-1:0] b_op[NUM_REQ];

  adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADDER_ARB_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      case ($urandom_range(0, 7))
        0:       begin a_op[i] = '1;        b_op[i] = $urandom_range(0, 3); end
        1:       begin a_op[i] = '1;        b_op[i] = '1;                   end
        default: begin a_op[i] = $urandom;  b_op[i] = $urandom;             end
      endcase
    end
  endtask

  // One clock cycle: drive, predict the grant from the rules, record the result.
  task automatic step(input logic [NUM_REQ-1:0] v, input bit rr, input bit rst);
    int                 g;
    bit                 can_acc;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH:0]     full;
    exp_t               e;
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = a_op[i];
      req_b[i*WIDTH +: WIDTH] = b_op[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    end
    can_acc = !rst && (sb.size() == 0 || rr);
    exp_rdy = (can_acc && g >= 0) ? NUM_REQ'(1 << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != '0) begin
      full    = {1'b0, a_op[g]} + {1'b0, b_op[g]};
      e.sum   = full[WIDTH-1:0];
      e.carry = full[WIDTH];
      e.id    = g;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
    end else if (exp_rdy != '0) begin
      sb.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
    end
  endtask

  // Monitor: whatever the DUT presents must match the oldest outstanding result.
  always @(negedge clk) begin
    #2;
    chk("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
    if (rsp_valid === 1'b1 && sb.size() != 0) begin
      chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
      chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
`ifdef ADDER_ARB_CARRY_EN
      chk("rsp_carry", 64'(rsp_carry), 64'(sb[0].carry));
`endif
      if (rsp_ready) void'(sb.pop_front());
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_sum",   64'(rsp_sum),   64'd0);
    chk("reset_id",    64'(rsp_id),    64'd0);
`ifdef ADDER_ARB_CARRY_EN
    chk("reset_carry", 64'(rsp_carry), 64'd0);
`endif

    // Single request 5+7
    a_op[0] = 32'd5; b_op[0] = 32'd7;
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_sum", 64'(rsp_sum), 64'd12);

    // All requesters valid, full throughput
    rand_ops();
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);

    // Backpressure with requester 1 waiting
    step(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Modulo wrap-around
    a_op[2] = 32'hFFFF_FFFF; b_op[2] = 32'h0000_0001;
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("wrap_sum", 64'(rsp_sum), 64'd0);
`ifdef ADDER_ARB_CARRY_EN
    chk("wrap_carry", 64'(rsp_carry), 64'd1);
`endif

    // Reset while FULL with id 2, then requesters 0 and 3 compete
    step(4'b0000, 1'b0, 1'b1);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    step(4'b1001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Fairness: grant 3, then 2 alone, then 2 and 3 together
    rand_ops();
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b1100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rand_ops();
      step(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the adder; legal range 2..8.
REQ-002 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 Port req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port req_b  input  NUM_REQ*WIDTH  flattened operand B; same packing as req_a.
REQ-009 Port rsp_valid  output  1  result register holds a valid sum.
REQ-010 Port rsp_ready  input  1  consumer accepts the result.
REQ-011 Port rsp_sum  output  WIDTH  registered a+b of the granted requester.
REQ-012 Port rsp_id  output  clog2(NUM_REQ)  index of the requester that produced rsp_sum.
REQ-013 Port rsp_carry  output  1  carry-out of the addition; present only when ADDER_ARB_CARRY_EN is defined.

Function
REQ-014 The block SHALL contain exactly one WIDTH-bit adder, shared among all requesters through a one-entry result register.
REQ-015 State machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 can_accept = EMPTY, or FULL with rsp_ready=1; when can_accept=0, all req_ready bits SHALL be 0.
REQ-017 When can_accept=1 and any req_valid bit is set, the block SHALL raise req_ready for exactly one requester, chosen round-robin.
REQ-018 Round-robin search SHALL start at index rr_ptr and proceed upward, wrapping from NUM_REQ-1 to 0.
REQ-019 On a transfer (req_valid[g] & req_ready[g]), rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-020 req_ready SHALL be combinational from req_valid, rr_ptr and state; requesters SHALL NOT make req_valid depend on req_ready.
REQ-021 Latency: on a transfer in cycle N, rsp_valid=1 in cycle N+1 with rsp_sum=(a+b) mod 2^WIDTH and rsp_id=g.
REQ-022 Transitions: EMPTY->FULL on a transfer; FULL->EMPTY on rsp_ready with no transfer; FULL->FULL on rsp_ready plus a transfer (new result loaded); FULL holds when rsp_ready=0.
REQ-023 While FULL and rsp_ready=0, rsp_sum, rsp_id and rsp_carry SHALL remain stable.
REQ-024 Sustained throughput SHALL be one sum per cycle when rsp_ready is held high.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; e.g. 0xFFFFFFFF+1 SHALL yield 0x00000000.
REQ-026 A requester that drops req_valid without being granted SHALL lose no state; no transfer is recorded for it.

Reset
REQ-027 While reset=1 at a clock edge: state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_carry=0, rr_ptr=0.
REQ-028 While reset=1, req_ready SHALL be all zeros.
REQ-029 A reset asserted mid-operation SHALL discard any held result; no response for that result SHALL appear after reset.

Configuration
REQ-030 Macro ADDER_ARB_CARRY_EN defined: rsp_carry port exists; the adder computes WIDTH+1 bits, and the MSB is registered into rsp_carry alongside rsp_sum.
REQ-031 Macro ADDER_ARB_CARRY_EN undefined: rsp_carry port and its register are absent; all other behaviour is unchanged.

Verification
REQ-032 Single request: req_valid=0001, a0=5, b0=7, rsp_ready=1 -> req_ready=0001 in that cycle; next cycle rsp_valid=1, rsp_sum=12, rsp_id=0.
REQ-033 All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 in consecutive cycles; rsp_id follows with a one-cycle lag.
REQ-034 Backpressure: result held with rsp_ready=0 for 3 cycles and req_valid=0010 -> req_ready=0000 and rsp_sum stable; on rsp_ready=1, requester 1 is granted in that same cycle.
REQ-035 Wrap-around: a=0xFFFFFFFF, b=0x00000001 -> rsp_sum=0x00000000; with ADDER_ARB_CARRY_EN, rsp_carry=1.
REQ-036 Reset mid-operation: FULL with rsp_id=2, then reset for 1 cycle -> rsp_valid=0 and rr_ptr=0; the next request from requester 3 with requester 0 also valid grants requester 0.
REQ-037 Fairness: requester 2 valid alone after grant of 3 (rr_ptr=0) -> grant 2; rr_ptr then becomes 3.
